// File: rtl/dac_stream_serializer.sv
// I2S-style DAC serializer: frame FIFO on the bit clock, left/right slots aligned to DACLRCK edges.
// Define DACSER_UNDERRUN_HOLD_EN to replay the last frame on underrun instead of sending silence.
module dac_stream_serializer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MONO_DUP   = 0
) (
    input  logic                          i_BCLK,
    input  logic                          i_rst_n,
    input  logic                          i_DACLRCK,
    input  logic                          i_play,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [2*DATA_W-1:0]           i_data,
    output logic                          o_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun,
    output logic [7:0]                    o_underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAD} state_t;

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level;
    logic                full, empty, push, pop;
    logic                lrck_d, primed;
    logic                edge_any, edge_fall, underrun_now;
    logic [2*DATA_W-1:0] frame_reg, head, subst, slot_frame;
    logic [DATA_W-1:0]   slot_data, shift_reg;
    logic [CW-1:0]       bit_cnt;
    state_t              state, state_next;

    assign full         = (level == LW'(FIFO_DEPTH));
    assign empty        = (level == '0);
    assign o_ready      = !full;
    assign o_level      = level;
    assign push         = i_valid && !full;
    assign edge_any     = primed && (i_DACLRCK != lrck_d);
    assign edge_fall    = edge_any && !i_DACLRCK;
    assign pop          = edge_fall && !empty;
    assign underrun_now = edge_fall && empty;
    assign head         = mem[rd_ptr];

`ifdef DACSER_UNDERRUN_HOLD_EN
    assign subst = frame_reg;
`else
    assign subst = '0;
`endif

    // A falling edge serialises the frame being popped this very cycle, so bypass frame_reg.
    assign slot_frame = edge_fall ? (empty ? subst : head) : frame_reg;

    always_comb begin
        slot_data = slot_frame[DATA_W-1:0];
        if (MONO_DUP == 0 && edge_fall) begin
            slot_data = slot_frame[2*DATA_W-1:DATA_W];
        end
    end

    assign o_DACDAT = i_play && (edge_any ? slot_data[DATA_W-1]
                                          : (state == S_SHIFT) && shift_reg[DATA_W-1]);

    always_ff @(posedge i_BCLK) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // primed masks the LRCK level seen on the first cycle out of reset.
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d         <= 1'b0;
            primed         <= 1'b0;
            frame_reg      <= '0;
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            lrck_d     <= i_DACLRCK;
            primed     <= 1'b1;
            o_underrun <= underrun_now;
            if (edge_fall) begin
                frame_reg <= slot_frame;
            end
            if (underrun_now && o_underrun_cnt != 8'hFF) begin
                o_underrun_cnt <= o_underrun_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (edge_any) begin
            shift_reg <= {slot_data[DATA_W-2:0], 1'b0};
            bit_cnt   <= CW'(DATA_W - 1);
        end else if (state == S_SHIFT) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (edge_any) begin
            state_next = S_SHIFT;
        end else if (state == S_SHIFT && bit_cnt == CW'(1)) begin
            state_next = S_PAD;
        end
    end

endmodule

// File: tb/tb_dac_stream_serializer.sv
// Bench for dac_stream_serializer: stereo and mono 16-bit instances share stimulus, plus a 24-bit
// instance driven with short LRCK periods. Expected slot words flow through a scoreboard queue.
module tb_dac_stream_serializer;

    typedef struct {
        logic [31:0] data;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic [15:0] exp_m;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, lrck, play, valid, valid24;
    logic [31:0] data;
    logic [47:0] data24;

    logic       ready, dacdat, underrun;
    logic [2:0] level;
    logic [7:0] ucnt;
    logic       ready_m, dacdat_m, underrun_m;
    logic [2:0] level_m;
    logic [7:0] ucnt_m;
    logic       ready_24, dacdat_24, underrun_24;
    logic [2:0] level_24;
    logic [7:0] ucnt_24;

    int         vectors = 0;
    int         miscompares = 0;
    int         model_level = 0;
    int         pulses24 = 0;
    logic [7:0] exp_cnt = 8'h00;
    vec_t       last_exp;
    vec_t       vecs [4];
    vec_t       sb [$];

    always #5 clk = ~clk;

    dac_stream_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .MONO_DUP(0)) dut (
        .i_BCLK(clk), .i_rst_n(rst_n), .i_DACLRCK(lrck), .i_play(play), .i_valid(valid),
        .o_ready(ready), .i_data(data), .o_DACDAT(dacdat), .o_level(level),
        .o_underrun(underrun), .o_underrun_cnt(ucnt));

    dac_stream_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .MONO_DUP(1)) dut_mono (
        .i_BCLK(clk), .i_rst_n(rst_n), .i_DACLRCK(lrck), .i_play(play), .i_valid(valid),
        .o_ready(ready_m), .i_data(data), .o_DACDAT(dacdat_m), .o_level(level_m),
        .o_underrun(underrun_m), .o_underrun_cnt(ucnt_m));

    dac_stream_serializer #(.DATA_W(24), .FIFO_DEPTH(4), .MONO_DUP(0)) dut_24 (
        .i_BCLK(clk), .i_rst_n(rst_n), .i_DACLRCK(lrck), .i_play(play), .i_valid(valid24),
        .o_ready(ready_24), .i_data(data24), .o_DACDAT(dacdat_24), .o_level(level_24),
        .o_underrun(underrun_24), .o_underrun_cnt(ucnt_24));

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0; valid = 1'b0; valid24 = 1'b0; data = '0; data24 = '0;
        lrck = 1'b0; play = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_level", 48'(level), 48'(0));
        checkOutput("reset_ready", 48'(ready), 48'(1));
        checkOutput("reset_dacdat", 48'(dacdat), 48'(0));
        checkOutput("reset_underrun", 48'(underrun), 48'(0));
        checkOutput("reset_underrun_cnt", 48'(ucnt), 48'(0));
        checkOutput("reset_level_24", 48'(level_24), 48'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        model_level = 0;
        exp_cnt = 8'h00;
        last_exp = '{32'h0, 16'h0, 16'h0, 16'h0};
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit accept;
        accept = (model_level < 4);
        valid = 1'b1;
        data = v.data;
        @(negedge clk);
        checkOutput("ready", 48'(ready), 48'(accept));
        checkOutput("ready_mono", 48'(ready_m), 48'(accept));
        @(posedge clk); #1;
        valid = 1'b0;
        if (accept) begin
            sb.push_back(v);
            model_level++;
        end
        @(negedge clk);
        checkOutput("level_after_push", 48'(level), 48'(model_level));
        @(posedge clk); #1;
    endtask

    // Drives one LRCK half for n cycles, capturing the serial bits of every instance.
    task automatic halfSlot(input logic lvl, input int n, input bit push_first, input logic [31:0] pdata,
                            output logic [15:0] w, output logic [15:0] wm, output logic [23:0] w24,
                            output int pad, output int pulses);
        lrck = lvl;
        if (push_first) begin
            valid = 1'b1;
            data = pdata;
        end
        w = '0; wm = '0; w24 = '0; pad = 0; pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i < 16) begin
                w  = {w[14:0], dacdat};
                wm = {wm[14:0], dacdat_m};
            end else if (dacdat) begin
                pad++;
            end
            if (i < 24) w24 = {w24[22:0], dacdat_24};
            if (underrun) pulses++;
            if (underrun_m) pulses++;
            if (underrun_24) pulses24++;
            @(posedge clk); #1;
            valid = 1'b0;
        end
    endtask

    task automatic runFrame(input int n, input bit push_first, input vec_t pv);
        vec_t        e;
        bit          ur;
        logic [15:0] w, wm;
        logic [23:0] w24;
        int          pad, pulses;
        if (model_level > 0) begin
            e = sb.pop_front();
            model_level--;
            ur = 1'b0;
        end else begin
            ur = 1'b1;
`ifdef DACSER_UNDERRUN_HOLD_EN
            e = last_exp;
`else
            e = '{32'h0, 16'h0, 16'h0, 16'h0};
`endif
            if (exp_cnt != 8'hFF) exp_cnt++;
        end
        last_exp = e;
        if (push_first) begin
            sb.push_back(pv);
            model_level++;
        end
        if (!play) begin
            e.exp_l = '0; e.exp_r = '0; e.exp_m = '0;
        end
        halfSlot(1'b0, n, push_first, pv.data, w, wm, w24, pad, pulses);
        checkOutput("left_slot", 48'(w), 48'(e.exp_l));
        checkOutput("mono_left_slot", 48'(wm), 48'(e.exp_m));
        if (n > 16) checkOutput("left_pad_ones", 48'(pad), 48'(0));
        checkOutput("underrun_pulses", 48'(pulses), ur ? 48'(2) : 48'(0));
        halfSlot(1'b1, n, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("right_slot", 48'(w), 48'(e.exp_r));
        checkOutput("mono_right_slot", 48'(wm), 48'(e.exp_m));
        checkOutput("right_underrun_pulses", 48'(pulses), 48'(0));
        checkOutput("underrun_cnt", 48'(ucnt), 48'(exp_cnt));
        checkOutput("underrun_cnt_mono", 48'(ucnt_m), 48'(exp_cnt));
        checkOutput("level_after_frame", 48'(level), 48'(model_level));
        checkOutput("level_after_frame_mono", 48'(level_m), 48'(model_level));
    endtask

    initial begin
        logic [15:0] w, wm;
        logic [23:0] w24;
        int          pad, pulses, ones;
        vec_t        popped, fifth, all_ones;

        vecs[0] = '{32'hA5C3_0F0F, 16'hA5C3, 16'h0F0F, 16'h0F0F};
        vecs[1] = '{32'h0000_8001, 16'h0000, 16'h8001, 16'h8001};
        vecs[2] = '{32'hFFFF_0001, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[3] = '{32'h8000_7FFE, 16'h8000, 16'h7FFE, 16'h7FFE};
        all_ones = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        doReset();

        // Right slot before any frame has been loaded carries zeros.
        halfSlot(1'b1, 32, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("right_before_frame", 48'(w), 48'(0));
        checkOutput("mono_right_before_frame", 48'(wm), 48'(0));

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            runFrame(32, 1'b0, vecs[0]);
        end

        // Fill the FIFO, hold a fifth frame across the next left edge.
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
        fifth = vecs[0];
        valid = 1'b1;
        data = fifth.data;
        @(negedge clk);
        checkOutput("ready_full", 48'(ready), 48'(0));
        checkOutput("level_full", 48'(level), 48'(4));
        @(posedge clk); #1;
        lrck = 1'b0;
        popped = sb.pop_front();
        model_level--;
        last_exp = popped;
        @(negedge clk);
        checkOutput("ready_no_bypass", 48'(ready), 48'(0));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("level_after_pop", 48'(level), 48'(3));
        checkOutput("ready_after_pop", 48'(ready), 48'(1));
        @(posedge clk); #1;
        valid = 1'b0;
        sb.push_back(fifth);
        model_level++;
        @(negedge clk);
        checkOutput("level_fifth_taken", 48'(level), 48'(model_level));
        repeat (29) @(posedge clk);
        #1;
        halfSlot(1'b1, 32, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("full_right_slot", 48'(w), 48'(popped.exp_r));
        checkOutput("full_mono_right_slot", 48'(wm), 48'(popped.exp_m));
        repeat (4) runFrame(32, 1'b0, vecs[0]);

        // Underrun, then underrun with a push on the same cycle.
        runFrame(32, 1'b0, vecs[0]);
        runFrame(32, 1'b1, vecs[3]);
        runFrame(32, 1'b0, vecs[0]);

        for (int i = 0; i < 300; i++) begin
            lrck = 1'b0;
            if (exp_cnt != 8'hFF) exp_cnt++;
            repeat (2) @(posedge clk);
            #1;
            lrck = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("underrun_saturated", 48'(ucnt), 48'(exp_cnt));
        checkOutput("underrun_saturated_mono", 48'(ucnt_m), 48'(exp_cnt));
        @(posedge clk); #1;

        // Muted playback still consumes one frame per LRCK period.
        play = 1'b0;
        for (int i = 1; i < 4; i++) applyStimulus(vecs[i]);
        repeat (3) runFrame(32, 1'b0, vecs[0]);
        play = 1'b1;

        // Reset in the middle of a left slot with frames queued.
        repeat (3) applyStimulus(all_ones);
        lrck = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("dacdat_before_reset", 48'(dacdat), 48'(1));
        checkOutput("level_before_reset", 48'(level), 48'(2));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("dacdat_async_reset", 48'(dacdat), 48'(0));
        checkOutput("dacdat_mono_async_reset", 48'(dacdat_m), 48'(0));
        checkOutput("level_async_reset", 48'(level), 48'(0));
        checkOutput("ready_async_reset", 48'(ready), 48'(1));
        @(posedge clk); #1;
        lrck = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        model_level = 0;
        exp_cnt = 8'h00;
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dacdat || dacdat_m || underrun) ones++;
        end
        checkOutput("quiet_after_release", 48'(ones), 48'(0));
        @(posedge clk); #1;

        // 24-bit instance with 8-cycle LRCK halves: slots truncate at each edge.
        valid24 = 1'b1;
        data24 = 48'hABCDEF_123456;
        @(posedge clk); #1;
        data24 = 48'h5A5A5A_C3C3C3;
        @(posedge clk); #1;
        valid24 = 1'b0;
        @(negedge clk);
        checkOutput("level_24_loaded", 48'(level_24), 48'(2));
        checkOutput("ready_24_loaded", 48'(ready_24), 48'(1));
        @(posedge clk); #1;
        pulses24 = 0;
        halfSlot(1'b0, 8, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("short_left_0", 48'(w24[7:0]), 48'(8'hAB));
        halfSlot(1'b1, 8, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("short_right_0", 48'(w24[7:0]), 48'(8'h12));
        halfSlot(1'b0, 8, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("short_left_1", 48'(w24[7:0]), 48'(8'h5A));
        halfSlot(1'b1, 8, 1'b0, 32'h0, w, wm, w24, pad, pulses);
        checkOutput("short_right_1", 48'(w24[7:0]), 48'(8'hC3));
        checkOutput("level_24_drained", 48'(level_24), 48'(0));
        checkOutput("underrun_cnt_24", 48'(ucnt_24), 48'(0));
        checkOutput("underrun_pulses_24", 48'(pulses24), 48'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
